// File: rtl/ram_init_ctrl.sv
// RAM initialisation controller: fills MEM_SIZE bytes from BASE_ADDR with
// 8-beat x 8-byte AXI INCR write bursts, one burst outstanding at a time.
//
// Ports:
//   clk, rst (async, active high)
//   AW: o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid, i_awready
//   W : o_wdata, o_wstrb, o_wlast, o_wvalid, i_wready
//   B : i_bresp, i_bvalid, o_bready
//   status: o_init_done, o_init_error
//
// Optional macro RAM_INIT_PATTERN_EN: o_wdata = {beat addr, ~beat addr}
// instead of FILL_WORD.
module ram_init_ctrl #(
  parameter int unsigned MEM_SIZE  = 32'h10000,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned ID_WIDTH  = 6,
  parameter logic [63:0] FILL_WORD = 64'h0,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ID_WIDTH-1:0] o_awid,
  output logic [31:0]         o_awaddr,
  output logic [7:0]          o_awlen,
  output logic [2:0]          o_awsize,
  output logic [1:0]          o_awburst,
  output logic                o_awvalid,
  input  logic                i_awready,
  output logic [63:0]         o_wdata,
  output logic [7:0]          o_wstrb,
  output logic                o_wlast,
  output logic                o_wvalid,
  input  logic                i_wready,
  input  logic [1:0]          i_bresp,
  input  logic                i_bvalid,
  output logic                o_bready,
  output logic                o_init_done,
  output logic                o_init_error
);

  localparam int unsigned NBURST = MEM_SIZE / 64;
  // One spare bit so the counter can never wrap.
  localparam int unsigned BW = $clog2(NBURST) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BURST =
    (NBURST == 0) ? '0 : BW'(NBURST - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    AW,
    W,
    B,
    DONE,
    ERR
  } state_t;

  state_t        state, state_d;
  logic [BW-1:0] burst_cnt, burst_d;
  logic [2:0]    beat_cnt, beat_d;
  logic [TW-1:0] tmo_cnt, tmo_d;
  logic          tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      beat_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      state     <= state_d;
      burst_cnt <= burst_d;
      beat_cnt  <= beat_d;
      tmo_cnt   <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state;
    burst_d      = burst_cnt;
    beat_d       = beat_cnt;
    tmo_d        = tmo_cnt;
    o_awvalid    = 1'b0;
    o_wvalid     = 1'b0;
    o_bready     = 1'b0;
    o_init_done  = 1'b0;
    o_init_error = 1'b0;
    unique case (state)
      IDLE: begin
        state_d = (NBURST == 0) ? DONE : AW;
      end
      AW: begin
        o_awvalid = 1'b1;
        if (i_awready) begin
          state_d = W;
          tmo_d   = '0;
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      W: begin
        o_wvalid = 1'b1;
        if (i_wready) begin
          tmo_d  = '0;
          beat_d = beat_cnt + 1'b1;
          if (beat_cnt == 3'd7) state_d = B;
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      B: begin
        o_bready = 1'b1;
        if (i_bvalid) begin
          tmo_d = '0;
          if (i_bresp != 2'b00) begin
            state_d = ERR;
          end else if (burst_cnt == LAST_BURST) begin
            state_d = DONE;
          end else begin
            burst_d = burst_cnt + 1'b1;
            state_d = AW;
          end
        end else if (tmo_hit) begin
          state_d = ERR;
        end else begin
          tmo_d = tmo_cnt + 1'b1;
        end
      end
      DONE: begin
        o_init_done = 1'b1;
      end
      ERR: begin
        o_init_done  = 1'b1;
        o_init_error = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_awid    = '0;
  assign o_awlen   = 8'd7;
  assign o_awsize  = 3'd3;
  assign o_awburst = 2'b01;
  assign o_wstrb   = 8'hFF;
  assign o_wlast   = (state == W) && (beat_cnt == 3'd7);
  assign o_awaddr  = BASE_ADDR + (32'(burst_cnt) << 6);

`ifdef RAM_INIT_PATTERN_EN
  logic [31:0] beat_addr;
  assign beat_addr = o_awaddr + (32'(beat_cnt) << 3);
  assign o_wdata   = {beat_addr, ~beat_addr};
`else
  assign o_wdata   = FILL_WORD;
`endif

endmodule

// File: tb/tb_ram_init_ctrl.sv
// Directed self-checking bench for ram_init_ctrl: fill, stalls, error
// response, timeout, mid-burst reset, zero size and beat data pattern.
module tb_ram_init_ctrl;

  localparam logic [63:0] FILL  = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] FILL2 = 64'h1111_2222_3333_4444;

  logic        clk;
  logic        rst;
  logic [5:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        done, err;

  logic [5:0]  d2_awid;
  logic [31:0] d2_awaddr;
  logic [7:0]  d2_awlen;
  logic [2:0]  d2_awsize;
  logic [1:0]  d2_awburst;
  logic        d2_awvalid;
  logic [63:0] d2_wdata;
  logic [7:0]  d2_wstrb;
  logic        d2_wlast, d2_wvalid, d2_bready;
  logic        d2_done, d2_err;

  logic [5:0]  d3_awid;
  logic [31:0] d3_awaddr;
  logic [7:0]  d3_awlen;
  logic [2:0]  d3_awsize;
  logic [1:0]  d3_awburst;
  logic        d3_awvalid;
  logic [63:0] d3_wdata;
  logic [7:0]  d3_wstrb;
  logic        d3_wlast, d3_wvalid, d3_bready;
  logic        d3_done, d3_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] aw_q[$];
  logic [63:0] wd_q[$];
  bit          wl_q[$];
  int          order_err;
  int          done_cyc;
  int          w_first;
  bit          done_seen;
  int          stall_tab[8] = '{0, 3, 1, 5, 2, 4, 0, 1};

  ram_init_ctrl #(
    .MEM_SIZE(32'h100), .BASE_ADDR(32'h0), .ID_WIDTH(6),
    .FILL_WORD(FILL), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .o_awid(awid), .o_awaddr(awaddr), .o_awlen(awlen),
    .o_awsize(awsize), .o_awburst(awburst),
    .o_awvalid(awvalid), .i_awready(awready),
    .o_wdata(wdata), .o_wstrb(wstrb), .o_wlast(wlast),
    .o_wvalid(wvalid), .i_wready(wready),
    .i_bresp(bresp), .i_bvalid(bvalid), .o_bready(bready),
    .o_init_done(done), .o_init_error(err)
  );

  ram_init_ctrl #(
    .MEM_SIZE(32'h40), .BASE_ADDR(32'h1000), .ID_WIDTH(6),
    .FILL_WORD(FILL2), .TIMEOUT(16)
  ) dut2 (
    .clk(clk), .rst(rst),
    .o_awid(d2_awid), .o_awaddr(d2_awaddr), .o_awlen(d2_awlen),
    .o_awsize(d2_awsize), .o_awburst(d2_awburst),
    .o_awvalid(d2_awvalid), .i_awready(1'b1),
    .o_wdata(d2_wdata), .o_wstrb(d2_wstrb), .o_wlast(d2_wlast),
    .o_wvalid(d2_wvalid), .i_wready(1'b1),
    .i_bresp(2'b00), .i_bvalid(1'b1), .o_bready(d2_bready),
    .o_init_done(d2_done), .o_init_error(d2_err)
  );

  ram_init_ctrl #(
    .MEM_SIZE(0), .BASE_ADDR(32'h0), .ID_WIDTH(6),
    .FILL_WORD(FILL), .TIMEOUT(16)
  ) dut3 (
    .clk(clk), .rst(rst),
    .o_awid(d3_awid), .o_awaddr(d3_awaddr), .o_awlen(d3_awlen),
    .o_awsize(d3_awsize), .o_awburst(d3_awburst),
    .o_awvalid(d3_awvalid), .i_awready(1'b0),
    .o_wdata(d3_wdata), .o_wstrb(d3_wstrb), .o_wlast(d3_wlast),
    .o_wvalid(d3_wvalid), .i_wready(1'b0),
    .i_bresp(2'b00), .i_bvalid(1'b0), .o_bready(d3_bready),
    .o_init_done(d3_done), .o_init_error(d3_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] exp_data(input logic [31:0] a);
`ifdef RAM_INIT_PATTERN_EN
    return {a, ~a};
`else
    return FILL;
`endif
  endfunction

  task automatic do_reset();
    rst     = 1'b1;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle-by-cycle AXI slave model; readies are set at negedge and the
  // handshake is recorded here since it completes on the next posedge.
  task automatic run_fill(input bit stall, input int err_burst,
                          input bit wr_off, input int stop_beats,
                          input int max_cyc);
    int aw_w = 0, aw_k = 0, w_w = 0, w_k = 0, b_w = 0, b_k = 0;
    bit aw_open = 0;
    aw_q.delete();
    wd_q.delete();
    wl_q.delete();
    order_err = 0;
    done_cyc  = -1;
    w_first   = -1;
    done_seen = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        done_cyc  = c;
        break;
      end
      if (stop_beats >= 0 && wd_q.size() == stop_beats) break;
      if (wvalid && w_first < 0) w_first = c;
      awready = !stall || (aw_w >= stall_tab[aw_k % 8]);
      if (awvalid) begin
        if (aw_open) order_err++;
        if (awready) begin
          aw_q.push_back(awaddr);
          aw_open = 1;
          aw_w = 0;
          aw_k++;
        end else aw_w++;
      end
      wready = !wr_off &&
               (!stall || (w_w >= stall_tab[(w_k + 3) % 8]));
      if (wvalid) begin
        if (!aw_open) order_err++;
        if (wready) begin
          wd_q.push_back(wdata);
          wl_q.push_back(wlast);
          w_w = 0;
          w_k++;
        end else w_w++;
      end
      bvalid = !stall || (b_w >= stall_tab[(b_k + 5) % 8]);
      bresp  = (b_k == err_burst) ? 2'b10 : 2'b00;
      if (bready) begin
        if (bvalid) begin
          aw_open = 0;
          b_w = 0;
          b_k++;
        end else b_w++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    awready = 1'b0;
    wready = 1'b0;
    bvalid = 1'b0;
    bresp = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({awvalid, wvalid, bready, wlast} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_valids got=%b want=0000",
               {awvalid, wvalid, bready, wlast});
    end
    n_checks++;
    if ({done, err} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_status got=%b want=00", {done, err});
    end
    n_checks++;
    if (awaddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_awaddr got=%h want=0", awaddr);
    end
    n_checks++;
    if (wdata !== exp_data(32'h0)) begin
      n_fail++;
      $display("FAIL reset_wdata got=%h want=%h", wdata, exp_data(0));
    end
    n_checks++;
    if ({awid, awlen, awsize, awburst, wstrb} !==
        {6'd0, 8'd7, 3'd3, 2'b01, 8'hFF}) begin
      n_fail++;
      $display("FAIL const_ports got=%h %h %h %h %h want=0 7 3 1 ff",
               awid, awlen, awsize, awburst, wstrb);
    end
  endtask

  task automatic test_zero_size();
    do_reset();
    n_checks++;
    if (d3_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_idle_done got=%b want=0", d3_done);
    end
    @(negedge clk);
    n_checks++;
    if ({d3_done, d3_err, d3_awvalid, d3_wvalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL zero_size got=%b want=1000",
               {d3_done, d3_err, d3_awvalid, d3_wvalid});
    end
  endtask

  // Runs right after test_zero_size, while dut2 is still in its first burst.
  task automatic test_pattern();
    logic [63:0] want;
    bit found = 0;
`ifdef RAM_INIT_PATTERN_EN
    want = 64'h00001000_FFFFEFFF;
`else
    want = FILL2;
`endif
    for (int i = 0; i < 8; i++) begin
      if (d2_wvalid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!found || d2_wdata !== want) begin
      n_fail++;
      $display("FAIL pattern_first_beat got=%h want=%h", d2_wdata, want);
    end
    n_checks++;
    if (d2_awaddr !== 32'h1000) begin
      n_fail++;
      $display("FAIL pattern_awaddr got=%h want=00001000", d2_awaddr);
    end
    for (int i = 0; i < 20 && !d2_done; i++) @(negedge clk);
    n_checks++;
    if ({d2_done, d2_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL pattern_done got=%b want=10", {d2_done, d2_err});
    end
  endtask

  task automatic test_fill(input bit stall);
    do_reset();
    run_fill(stall, -1, 1'b0, -1, 600);
    n_checks++;
    if (!done_seen || err !== 1'b0) begin
      n_fail++;
      $display("FAIL fill%0d_done got=%b err=%b want=1 0",
               stall, done_seen, err);
    end
    n_checks++;
    if (aw_q.size() != 4 || wd_q.size() != 32) begin
      n_fail++;
      $display("FAIL fill%0d_counts got=%0d/%0d want=4/32",
               stall, aw_q.size(), wd_q.size());
    end
    for (int i = 0; i < aw_q.size() && i < 4; i++) begin
      n_checks++;
      if (aw_q[i] !== 32'(64 * i)) begin
        n_fail++;
        $display("FAIL fill%0d_awaddr[%0d] got=%h want=%h",
                 stall, i, aw_q[i], 32'(64 * i));
      end
    end
    for (int i = 0; i < wd_q.size() && i < 32; i++) begin
      n_checks++;
      if (wd_q[i] !== exp_data(32'(8 * i)) ||
          wl_q[i] !== ((i % 8) == 7)) begin
        n_fail++;
        $display("FAIL fill%0d_beat[%0d] got=%h/%b want=%h/%b",
                 stall, i, wd_q[i], wl_q[i], exp_data(32'(8 * i)),
                 (i % 8) == 7);
      end
    end
    n_checks++;
    if (order_err != 0) begin
      n_fail++;
      $display("FAIL fill%0d_order got=%0d want=0", stall, order_err);
    end
  endtask

  task automatic test_bresp_error();
    int extra_aw = 0;
    do_reset();
    run_fill(1'b0, 2, 1'b0, -1, 200);
    n_checks++;
    if (!done_seen || err !== 1'b1) begin
      n_fail++;
      $display("FAIL bresp_err got=%b/%b want=1/1", done_seen, err);
    end
    n_checks++;
    if (aw_q.size() != 3) begin
      n_fail++;
      $display("FAIL bresp_aw_count got=%0d want=3", aw_q.size());
    end
    awready = 1'b1;
    wready = 1'b1;
    bvalid = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (awvalid || !done || !err) extra_aw++;
    end
    n_checks++;
    if (extra_aw != 0) begin
      n_fail++;
      $display("FAIL bresp_terminal got=%0d want=0", extra_aw);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    run_fill(1'b0, -1, 1'b1, -1, 200);
    n_checks++;
    if (!done_seen || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err got=%b/%b want=1/1", done_seen, err);
    end
    n_checks++;
    if (done_cyc - w_first != 16) begin
      n_fail++;
      $display("FAIL timeout_cycles got=%0d want=16", done_cyc - w_first);
    end
    n_checks++;
    if (aw_q.size() != 1 || wd_q.size() != 0) begin
      n_fail++;
      $display("FAIL timeout_traffic got=%0d/%0d want=1/0",
               aw_q.size(), wd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_fill(1'b0, -1, 1'b0, 12, 200);
    n_checks++;
    if (wd_q.size() != 12 || wvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup got=%0d/%b want=12/1",
               wd_q.size(), wvalid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({awvalid, wvalid, bready, wlast, done, err} !== 6'b0 ||
        awaddr !== 32'h0 || wdata !== exp_data(32'h0)) begin
      n_fail++;
      $display("FAIL mid_async got=%b %h %h want=000000 0 %h",
               {awvalid, wvalid, bready, wlast, done, err},
               awaddr, wdata, exp_data(32'h0));
    end
    @(negedge clk);
    rst = 1'b0;
    run_fill(1'b0, -1, 1'b0, -1, 200);
    n_checks++;
    if (aw_q.size() == 0 || aw_q[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_restart_addr got=%h want=0",
               (aw_q.size() == 0) ? 32'hx : aw_q[0]);
    end
    n_checks++;
    if (!done_seen || err !== 1'b0 || aw_q.size() != 4 ||
        wd_q.size() != 32) begin
      n_fail++;
      $display("FAIL mid_restart_fill got=%b/%b %0d/%0d want=1/0 4/32",
               done_seen, err, aw_q.size(), wd_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_size();
    test_pattern();
    test_fill(1'b0);
    test_fill(1'b1);
    test_bresp_error();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_init_ctrl.md
RAM_INIT_CTRL -- requirements
Module: ram_init_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 32'h10000, bytes to fill; multiple of 64.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0, first byte address filled; 64-byte aligned.
REQ-003 SHALL have parameter ID_WIDTH, default 6, width of o_awid.
REQ-004 SHALL have parameter FILL_WORD, default 64'h0, constant fill data.
REQ-005 SHALL have parameter TIMEOUT, default 1024, maximum cycles waited in any handshake state.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic rises on clk.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port o_awid, output, ID_WIDTH, constant 0.
REQ-009 SHALL have port o_awaddr, output, 32, burst start address.
REQ-010 SHALL have ports o_awlen (8, constant 7), o_awsize (3, constant 3) and o_awburst (2, constant INCR 2'b01), all outputs.
REQ-011 SHALL have ports o_awvalid (output, 1) and i_awready (input, 1), AW handshake.
REQ-012 SHALL have ports o_wdata (output, 64), o_wstrb (output, 8, constant 8'hFF) and o_wlast (output, 1).
REQ-013 SHALL have ports o_wvalid (output, 1) and i_wready (input, 1), W handshake.
REQ-014 SHALL have ports i_bresp (input, 2), i_bvalid (input, 1) and o_bready (output, 1), B handshake.
REQ-015 SHALL have ports o_init_done (output, 1), fill finished, and o_init_error (output, 1), fill failed; both feed the core's i_ram_init_done and i_ram_init_error.

Function
REQ-016 SHALL implement states IDLE, AW, W, B, DONE and ERR.
REQ-017 SHALL leave IDLE for AW on the first clk edge after rst deasserts.
REQ-018 SHALL issue MEM_SIZE/64 bursts of 8 beats x 8 bytes; burst n uses o_awaddr = BASE_ADDR + 64*n.
REQ-019 AW: SHALL hold o_awvalid high and o_awaddr stable until i_awready is sampled high, then move to W.
REQ-020 W: SHALL hold o_wvalid high; SHALL advance the beat counter (0..7) only when o_wvalid and i_wready are both high; SHALL assert o_wlast only on beat 7; after the beat-7 handshake, SHALL move to B.
REQ-021 SHALL never assert o_wvalid before the AW handshake of the same burst, and SHALL have at most one burst outstanding.
REQ-022 B: SHALL hold o_bready high; on i_bvalid with i_bresp==2'b00, SHALL go to AW for the next burst, or to DONE after the last burst.
REQ-023 B: SHALL go to ERR on i_bvalid with i_bresp!=2'b00.
REQ-024 In each of AW, W and B, SHALL count cycles spent without a handshake and go to ERR when the count reaches TIMEOUT; the count clears on every handshake.
REQ-025 DONE: SHALL set o_init_done=1 and o_init_error=0.
REQ-026 ERR: SHALL set o_init_done=1 and o_init_error=1.
REQ-027 DONE and ERR SHALL be terminal until reset.
REQ-028 o_awvalid, o_wvalid and o_bready SHALL be high only in AW, W and B respectively.
REQ-029 The burst counter SHALL be sized ceil(log2(MEM_SIZE/64))+1 bits and SHALL NOT wrap.
REQ-030 MEM_SIZE==0 SHALL go IDLE -> DONE with no AXI traffic.

Reset
REQ-031 While rst is high, SHALL hold state IDLE with all counters 0, o_awvalid=o_wvalid=o_bready=0, o_wlast=0, o_awaddr=BASE_ADDR, o_wdata=FILL_WORD, and o_init_done=o_init_error=0.
REQ-032 rst asserted mid-burst SHALL abort immediately; after deassert, the fill restarts from burst 0.

Configuration
REQ-033 With macro RAM_INIT_PATTERN_EN defined, o_wdata SHALL be {beat address, ~beat address} (upper 32 bits = byte address of the beat, lower 32 bits = its inverse); without it, o_wdata SHALL be FILL_WORD.

Verification
REQ-034 MEM_SIZE=0x100, awready/wready/bvalid always 1, bresp=0 -> 4 bursts at 0x0, 0x40, 0x80, 0xC0; 32 W beats; o_wlast on every 8th beat; done=1, error=0.
REQ-035 Random 0-5 cycle stalls on awready, wready and bvalid -> same address and data sequence; no beat lost or duplicated; o_wvalid never precedes its AW handshake.
REQ-036 Burst 2 returns bresp=2'b10 -> ERR; done=1, error=1; no further AW issued.
REQ-037 TIMEOUT=16, wready held 0 -> ERR 16 cycles after W entry.
REQ-038 rst pulsed during beat 4 of burst 1 -> outputs return to reset values asynchronously; the next AW is at BASE_ADDR.
REQ-039 RAM_INIT_PATTERN_EN defined, BASE_ADDR=0x1000 -> first beat o_wdata = 64'h00001000_FFFFEFFF.
